// File: rtl/ft601_bus_scheduler_if.sv
// ---------------------------------------------------------------------------
// ft601_bus_scheduler_if
//
// Groups every signal that the FT601 bus scheduler exchanges with the pads
// and with the streaming FIFOs.
//
//   Pad side (FT601 245-synchronous FIFO bus)
//     i_ftdi_txe_n, i_ftdi_rxf_n   FT601 FIFO status (active low)
//     i_ftdi_data, i_ftdi_be       bus data / byte enables from the pads
//     o_ftdi_data, o_ftdi_be       bus data / byte enables to the pads
//     o_ftdi_drive                 pad output enable for data/be
//     o_ftdi_oe_n, o_ftdi_rd_n,
//     o_ftdi_wr_n                  FT601 strobes
//   TX stream (FPGA -> host)
//     i_tx_valid, i_tx_data, i_tx_be, o_tx_ready
//   RX sink (host -> FPGA)
//     o_rx_valid, o_rx_data, o_rx_be, i_rx_afull
//
// Modport master belongs to the scheduler; modport slave is the view taken
// by the surrounding pads/FIFOs.
// ---------------------------------------------------------------------------
interface ft601_bus_scheduler_if;
    logic        i_ftdi_txe_n;
    logic        i_ftdi_rxf_n;
    logic [31:0] i_ftdi_data;
    logic [3:0]  i_ftdi_be;
    logic [31:0] o_ftdi_data;
    logic [3:0]  o_ftdi_be;
    logic        o_ftdi_drive;
    logic        o_ftdi_oe_n;
    logic        o_ftdi_rd_n;
    logic        o_ftdi_wr_n;

    logic        i_tx_valid;
    logic [31:0] i_tx_data;
    logic [3:0]  i_tx_be;
    logic        o_tx_ready;

    logic        o_rx_valid;
    logic [31:0] o_rx_data;
    logic [3:0]  o_rx_be;
    logic        i_rx_afull;

    modport master (
        input  i_ftdi_txe_n, i_ftdi_rxf_n, i_ftdi_data, i_ftdi_be,
               i_tx_valid, i_tx_data, i_tx_be, i_rx_afull,
        output o_ftdi_data, o_ftdi_be, o_ftdi_drive,
               o_ftdi_oe_n, o_ftdi_rd_n, o_ftdi_wr_n,
               o_tx_ready, o_rx_valid, o_rx_data, o_rx_be
    );

    modport slave (
        output i_ftdi_txe_n, i_ftdi_rxf_n, i_ftdi_data, i_ftdi_be,
               i_tx_valid, i_tx_data, i_tx_be, i_rx_afull,
        input  o_ftdi_data, o_ftdi_be, o_ftdi_drive,
               o_ftdi_oe_n, o_ftdi_rd_n, o_ftdi_wr_n,
               o_tx_ready, o_rx_valid, o_rx_data, o_rx_be
    );
endinterface

// File: rtl/ft601_bus_scheduler.sv
// ---------------------------------------------------------------------------
// ft601_bus_scheduler
//
// Time-shares the FT601 245-synchronous FIFO bus between one TX stream
// (FPGA -> host) and one RX sink (host -> FPGA). Generates the FT601
// strobes, owns the pad drive enable, inserts a turnaround cycle between
// directions and caps every grant at MAX_BURST words so that neither
// direction can starve the other.
//
// Parameters
//   MAX_BURST    maximum words moved per direction grant (>= 2)
// Ports
//   i_ftdi_clk   FT601 bus clock, all logic on the rising edge
//   i_reset_n    asynchronous active-low reset
//   bus          pad + stream signals (ft601_bus_scheduler_if.master)
//   o_fsm        current state, for debug pins
// ---------------------------------------------------------------------------
module ft601_bus_scheduler #(
    parameter int MAX_BURST = 256
) (
    input  logic                         i_ftdi_clk,
    input  logic                         i_reset_n,
    ft601_bus_scheduler_if.master        bus,
    output logic [3:0]                   o_fsm
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] RX_OE    = 4'd1;
    localparam logic [3:0] RX_READ  = 4'd2;
    localparam logic [3:0] RX_END   = 4'd3;
    localparam logic [3:0] TX_WRITE = 4'd4;
    localparam logic [3:0] TX_END   = 4'd5;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    logic [3:0]    state, state_next;
    logic [CW-1:0] count, count_next;
    logic          last_dir, last_dir_next;
    logic          wr_n, wr_n_next;
    logic          oe_n, rd_n, drive;
    logic [31:0]   data_q;
    logic [3:0]    be_q;
    logic          rx_valid;
    logic [31:0]   rx_data;
    logic [3:0]    rx_be;

    logic          rx_req, tx_req, grant_tx, grant_rx;
    logic          tx_full, tx_ready, tx_load, tx_accept, rx_xfer;
    logic [CW-1:0] committed;

    // NOTE: always_comb uses blocking assignments and gives every output a
    // default first, so no path leaves a signal unassigned and no latch is
    // inferred.
    always_comb begin
        rx_req   = !bus.i_ftdi_rxf_n && !bus.i_rx_afull;
        tx_req   = !bus.i_ftdi_txe_n && bus.i_tx_valid;
        // On a tie the direction not served last wins.
        grant_tx = tx_req && (!rx_req || last_dir == DIR_RX);
        grant_rx = rx_req && !grant_tx;

        // The TX output register holds a word exactly while wr_n is low.
        tx_full   = !wr_n;
        committed = count + CW'(tx_full);
        tx_ready  = (state == TX_WRITE) && (wr_n || !bus.i_ftdi_txe_n)
                    && (committed < BURST_MAX);
        tx_load   = tx_ready && bus.i_tx_valid;
        tx_accept = (state == TX_WRITE) && tx_full && !bus.i_ftdi_txe_n;
        // rd_n is low for the whole of RX_READ, so only rxf_n gates a word.
        rx_xfer   = (state == RX_READ) && !bus.i_ftdi_rxf_n;

        state_next    = state;
        count_next    = count;
        last_dir_next = last_dir;
        wr_n_next     = 1'b1;

        case (state)
            IDLE: begin
                if (grant_tx) begin
                    state_next    = TX_WRITE;
                    count_next    = '0;
                    last_dir_next = DIR_TX;
                end else if (grant_rx) begin
                    state_next    = RX_OE;
                    count_next    = '0;
                    last_dir_next = DIR_RX;
                end
            end
            RX_OE: state_next = RX_READ;
            RX_READ: begin
                if (rx_xfer) count_next = count + CNT_ONE;
                // afull seen together with a transfer still takes that word:
                // that is the single extra word the sink must absorb.
                if (bus.i_ftdi_rxf_n || bus.i_rx_afull || count_next == BURST_MAX)
                    state_next = RX_END;
            end
            RX_END: state_next = IDLE;
            TX_WRITE: begin
                wr_n_next = wr_n;
                if (tx_accept) count_next = count + CNT_ONE;
                if (tx_load)
                    wr_n_next = 1'b0;
                else if (tx_accept)
                    wr_n_next = 1'b1;
                // Only leave once the output register has drained, so a word
                // stalled by txe_n is never abandoned on the bus.
                if (wr_n_next && (!bus.i_tx_valid || bus.i_ftdi_txe_n
                                  || count_next == BURST_MAX))
                    state_next = TX_END;
            end
            TX_END: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_ftdi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            count    <= '0;
            last_dir <= DIR_RX;
            wr_n     <= 1'b1;
            oe_n     <= 1'b1;
            rd_n     <= 1'b1;
            drive    <= 1'b0;
            data_q   <= '0;
            be_q     <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_be    <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            last_dir <= last_dir_next;
            wr_n     <= wr_n_next;
            // Strobes and drive are decoded from the next state so they are
            // registered yet line up exactly with the state they belong to;
            // drive and oe_n come from disjoint states and never overlap.
            oe_n     <= !(state_next == RX_OE || state_next == RX_READ);
            rd_n     <= !(state_next == RX_READ);
            drive    <= (state_next == TX_WRITE);
            rx_valid <= rx_xfer;
            if (rx_xfer) begin
                rx_data <= bus.i_ftdi_data;
                rx_be   <= bus.i_ftdi_be;
            end
            if (tx_load) begin
                data_q <= bus.i_tx_data;
                be_q   <= bus.i_tx_be;
            end
        end
    end

    assign bus.o_ftdi_data  = data_q;
    assign bus.o_ftdi_be    = be_q;
    assign bus.o_ftdi_drive = drive;
    assign bus.o_ftdi_oe_n  = oe_n;
    assign bus.o_ftdi_rd_n  = rd_n;
    assign bus.o_ftdi_wr_n  = wr_n;
    assign bus.o_tx_ready   = tx_ready;
    assign bus.o_rx_valid   = rx_valid;
    assign bus.o_rx_data    = rx_data;
    assign bus.o_rx_be      = rx_be;
    assign o_fsm            = state;

endmodule

// File: tb/tb_ft601_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ft601_bus_scheduler
//
// Directed bench for ft601_bus_scheduler with MAX_BURST = 4. One initial
// block steps the bus cycle by cycle, playing the FT601 and the stream
// FIFOs, and compares the DUT against hand-computed values. Inputs change
// 1 ns after the rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_ft601_bus_scheduler;
    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] fsm;
    int         passed = 0;
    int         failed = 0;
    int         total  = 0;

    ft601_bus_scheduler_if bus();

    ft601_bus_scheduler #(.MAX_BURST(MAX_BURST)) dut (
        .i_ftdi_clk (clk),
        .i_reset_n  (rst_n),
        .bus        (bus),
        .o_fsm      (fsm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {fsm, oe_n, rd_n, wr_n, drive}
    task automatic expect_bus(input string tag, input logic [3:0] e_fsm, input logic e_oe,
                              input logic e_rd, input logic e_wr, input logic e_drv);
        check(tag, 64'({fsm, bus.o_ftdi_oe_n, bus.o_ftdi_rd_n, bus.o_ftdi_wr_n, bus.o_ftdi_drive}),
              64'({e_fsm, e_oe, e_rd, e_wr, e_drv}));
    endtask

    // {wr_n, be, data} on the pad side
    task automatic expect_tx(input string tag, input logic e_wr, input logic [3:0] e_be,
                             input logic [31:0] e_data);
        check(tag, 64'({bus.o_ftdi_wr_n, bus.o_ftdi_be, bus.o_ftdi_data}),
              64'({e_wr, e_be, e_data}));
    endtask

    // {valid, be, data} on the RX sink side
    task automatic expect_rx(input string tag, input logic e_valid, input logic [3:0] e_be,
                             input logic [31:0] e_data);
        check(tag, 64'({bus.o_rx_valid, bus.o_rx_be, bus.o_rx_data}),
              64'({e_valid, e_be, e_data}));
    endtask

    initial begin
        bus.i_ftdi_txe_n = 1'b1;
        bus.i_ftdi_rxf_n = 1'b1;
        bus.i_ftdi_data  = '0;
        bus.i_ftdi_be    = '0;
        bus.i_tx_valid   = 1'b0;
        bus.i_tx_data    = '0;
        bus.i_tx_be      = '0;
        bus.i_rx_afull   = 1'b0;
        rst_n            = 1'b0;

        // ---------------- reset and idle ----------------
        tick(); tick();
        expect_bus("reset_strobes", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reset_outputs",
              64'({bus.o_ftdi_data, bus.o_ftdi_be, bus.o_rx_valid, bus.o_tx_ready}), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_bus($sformatf("idle_hold_%0d", i), 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        end

        // ---------------- TX burst of 3 words ----------------
        bus.i_ftdi_txe_n = 1'b0;
        bus.i_tx_valid   = 1'b1;
        bus.i_tx_data    = 32'hA5A5_0001;
        bus.i_tx_be      = 4'hF;
        #1 check("tx_ready_in_idle", 64'(bus.o_tx_ready), 64'd0);
        tick();
        expect_bus("tx_grant", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        check("tx_ready_first", 64'(bus.o_tx_ready), 64'd1);
        tick();
        expect_tx("tx_w1", 1'b0, 4'hF, 32'hA5A5_0001);
        bus.i_tx_data = 32'hA5A5_0002;
        tick();
        expect_tx("tx_w2", 1'b0, 4'hF, 32'hA5A5_0002);
        bus.i_tx_data = 32'hA5A5_0003;
        tick();
        expect_tx("tx_w3", 1'b0, 4'hF, 32'hA5A5_0003);
        bus.i_tx_valid = 1'b0;
        tick();
        expect_bus("tx_end", 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("tx_back_idle", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.i_ftdi_txe_n = 1'b1;

        // ---------------- RX burst of 3 words, ended by rxf_n ----------------
        bus.i_ftdi_rxf_n = 1'b0;
        bus.i_ftdi_data  = 32'hB000_0001;
        bus.i_ftdi_be    = 4'h1;
        tick();
        expect_bus("rx_oe", 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("rx_read", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rx_no_word_yet", 64'(bus.o_rx_valid), 64'd0);
        tick();
        expect_rx("rx_w1", 1'b1, 4'h1, 32'hB000_0001);
        bus.i_ftdi_data = 32'hB000_0002;
        bus.i_ftdi_be   = 4'h3;
        tick();
        expect_rx("rx_w2", 1'b1, 4'h3, 32'hB000_0002);
        bus.i_ftdi_data = 32'hB000_0003;
        bus.i_ftdi_be   = 4'hF;
        tick();
        expect_rx("rx_w3", 1'b1, 4'hF, 32'hB000_0003);
        bus.i_ftdi_rxf_n = 1'b1;
        tick();
        expect_bus("rx_end", 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rx_valid_dropped", 64'(bus.o_rx_valid), 64'd0);
        tick();
        expect_bus("rx_back_idle", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // ---------------- both pending: alternating bursts of MAX_BURST ----------------
        bus.i_ftdi_txe_n = 1'b0;
        bus.i_tx_valid   = 1'b1;
        bus.i_tx_data    = 32'hD000_0001;
        bus.i_tx_be      = 4'hF;
        bus.i_ftdi_rxf_n = 1'b0;
        bus.i_ftdi_data  = 32'hE000_0001;
        bus.i_ftdi_be    = 4'hF;
        tick();
        expect_bus("alt_tx_first", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= MAX_BURST; i++) begin
            tick();
            expect_tx($sformatf("alt_tx_w%0d", i), 1'b0, 4'hF, 32'hD000_0000 + 32'(i));
            bus.i_tx_data = 32'hD000_0000 + 32'(i + 1);
            #1 check($sformatf("alt_tx_ready_%0d", i), 64'(bus.o_tx_ready), 64'(i < MAX_BURST));
        end
        tick();
        expect_bus("alt_tx_end", 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("alt_turnaround", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("alt_rx_grant", 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("alt_rx_read", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= MAX_BURST; i++) begin
            tick();
            expect_rx($sformatf("alt_rx_w%0d", i), 1'b1, 4'hF, 32'hE000_0000 + 32'(i));
            bus.i_ftdi_data = 32'hE000_0000 + 32'(i + 1);
        end
        expect_bus("alt_rx_end", 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("alt_rx_idle", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("alt_tx_again", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        bus.i_tx_valid   = 1'b0;
        bus.i_ftdi_rxf_n = 1'b1;
        tick();
        expect_bus("alt_tx_empty_end", 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("alt_idle", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // ---------------- txe_n stall mid-burst ----------------
        bus.i_tx_valid = 1'b1;
        bus.i_tx_data  = 32'hC000_0001;
        bus.i_tx_be    = 4'h5;
        tick();
        expect_bus("stall_grant", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        expect_tx("stall_w1", 1'b0, 4'h5, 32'hC000_0001);
        bus.i_tx_data    = 32'hC000_0002;
        bus.i_tx_be      = 4'hA;
        bus.i_ftdi_txe_n = 1'b1;
        #1 check("stall_ready_blocked", 64'(bus.o_tx_ready), 64'd0);
        tick();
        expect_tx("stall_hold_1", 1'b0, 4'h5, 32'hC000_0001);
        tick();
        expect_tx("stall_hold_2", 1'b0, 4'h5, 32'hC000_0001);
        bus.i_ftdi_txe_n = 1'b0;
        #1 check("stall_ready_resume", 64'(bus.o_tx_ready), 64'd1);
        tick();
        expect_tx("stall_w2", 1'b0, 4'hA, 32'hC000_0002);
        bus.i_tx_valid = 1'b0;
        tick();
        expect_bus("stall_end", 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("stall_idle", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.i_ftdi_txe_n = 1'b1;

        // ---------------- rx_afull raised mid-RX ----------------
        bus.i_ftdi_rxf_n = 1'b0;
        bus.i_ftdi_data  = 32'hF000_0001;
        bus.i_ftdi_be    = 4'hF;
        tick();
        expect_bus("afull_oe", 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("afull_read", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_rx("afull_w1", 1'b1, 4'hF, 32'hF000_0001);
        bus.i_ftdi_data = 32'hF000_0002;
        bus.i_rx_afull  = 1'b1;
        tick();
        expect_bus("afull_stop", 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_rx("afull_extra_word", 1'b1, 4'hF, 32'hF000_0002);
        tick();
        check("afull_no_more", 64'({fsm, bus.o_rx_valid}), 64'({4'd0, 1'b0}));
        tick();
        expect_bus("afull_blocks_grant", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.i_rx_afull   = 1'b0;
        bus.i_ftdi_rxf_n = 1'b1;

        // ---------------- reset pulsed mid-TX ----------------
        bus.i_ftdi_txe_n = 1'b0;
        bus.i_tx_valid   = 1'b1;
        bus.i_tx_data    = 32'h9999_0001;
        bus.i_tx_be      = 4'hF;
        tick();
        expect_bus("rst_tx_grant", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        expect_tx("rst_tx_w1", 1'b0, 4'hF, 32'h9999_0001);
        bus.i_tx_data = 32'h9999_0002;
        #2 rst_n = 1'b0;
        #1 expect_bus("rst_async_release", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_async_outputs", 64'({bus.o_ftdi_data, bus.o_ftdi_be, bus.o_tx_ready}), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        expect_bus("rst_regrant", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        expect_tx("rst_no_replay", 1'b0, 4'hF, 32'h9999_0002);
        bus.i_tx_valid = 1'b0;
        tick();
        expect_bus("rst_tx_end", 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_bus("rst_final_idle", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
